// File: rtl/rob_multi_cdb.sv
// Reorder buffer with multi-port CDB writeback, operand lookup/bypass and in-order commit.
// Lower CDB port index wins when several ports target the same tag in one cycle.
module rob_multi_cdb #(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 16,
    parameter int TAG_W          = $clog2(DEPTH),
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CDB_PORTS      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall_i,
    input  logic                          flush_i,
    input  logic                          issue_en_i,
    input  logic [REG_ADDR_WIDTH-1:0]     issue_dest_i,
    output logic [TAG_W-1:0]              issue_tag_o,
    input  logic [TAG_W-1:0]              rs1_tag_i,
    input  logic [TAG_W-1:0]              rs2_tag_i,
    output logic                          rs1_valid_o,
    output logic                          rs2_valid_o,
    output logic [XLEN-1:0]               rs1_value_o,
    output logic [XLEN-1:0]               rs2_value_o,
    input  logic [CDB_PORTS-1:0]          cdb_valid_i,
    input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag_i,
    input  logic [CDB_PORTS*XLEN-1:0]     cdb_value_i,
    input  logic                          commit_ready_i,
    output logic                          commit_en_o,
    output logic [REG_ADDR_WIDTH-1:0]     commit_dest_o,
    output logic [XLEN-1:0]               commit_value_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [TAG_W:0]                count_o
);

    logic [DEPTH-1:0]                     busy;
    logic [DEPTH-1:0]                     valid;
    logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] dest;
    logic [DEPTH-1:0][XLEN-1:0]           value;
    logic [TAG_W-1:0]                     head;
    logic [TAG_W-1:0]                     tail;
    logic [TAG_W:0]                       count;

    logic [CDB_PORTS-1:0][TAG_W-1:0]      ctag;
    logic [CDB_PORTS-1:0][XLEN-1:0]       cval;
    logic [DEPTH-1:0]                     cdb_we;
    logic [DEPTH-1:0][XLEN-1:0]           cdb_wd;
    logic [1:0][TAG_W-1:0]                rs_tag;
    logic [1:0]                           rs_v;
    logic [1:0][XLEN-1:0]                 rs_d;
    logic                                 issue_fire;

    assign ctag   = cdb_tag_i;
    assign cval   = cdb_value_i;
    assign rs_tag = {rs2_tag_i, rs1_tag_i};

    assign full_o      = (count == (TAG_W+1)'(DEPTH));
    assign empty_o     = (count == '0);
    assign count_o     = count;
    assign issue_tag_o = tail;
    assign issue_fire  = issue_en_i & ~full_o & ~stall_i & ~flush_i;

    assign commit_en_o    = busy[head] & valid[head] & commit_ready_i & ~stall_i & ~flush_i;
    assign commit_dest_o  = dest[head];
    assign commit_value_o = value[head];

    // Scan ports high to low so the lowest matching port is the last assignment.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            cdb_we[e] = 1'b0;
            cdb_wd[e] = '0;
            for (int p = CDB_PORTS-1; p >= 0; p--) begin
                if (cdb_valid_i[p] && ctag[p] == TAG_W'(e) && busy[e]) begin
                    cdb_we[e] = 1'b1;
                    cdb_wd[e] = cval[p];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            rs_v[r] = 1'b0;
            rs_d[r] = '0;
            if (valid[rs_tag[r]]) begin
                rs_v[r] = 1'b1;
                rs_d[r] = value[rs_tag[r]];
            end else begin
                for (int p = CDB_PORTS-1; p >= 0; p--) begin
                    if (cdb_valid_i[p] && ctag[p] == rs_tag[r] && busy[rs_tag[r]]) begin
                        rs_v[r] = 1'b1;
                        rs_d[r] = cval[p];
                    end
                end
            end
        end
    end

    assign rs1_valid_o = rs_v[0];
    assign rs1_value_o = rs_d[0];
    assign rs2_valid_o = rs_v[1];
    assign rs2_value_o = rs_d[1];

    // Commit clears valid too, so valid always implies busy for lookups.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            busy  <= '0;
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (cdb_we[e]) begin
                    valid[e] <= 1'b1;
                    value[e] <= cdb_wd[e];
                end
            end
            if (issue_fire) begin
                busy[tail]  <= 1'b1;
                valid[tail] <= 1'b0;
                dest[tail]  <= issue_dest_i;
                tail        <= tail + 1'b1;
            end
            if (commit_en_o) begin
                busy[head]  <= 1'b0;
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (issue_fire && !commit_en_o)
                count <= count + 1'b1;
            else if (!issue_fire && commit_en_o)
                count <= count - 1'b1;
        end
    end

endmodule

// File: doc/rob_multi_cdb.md
ROB_MULTI_CDB -- requirements
Module: rob_multi_cdb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter DEPTH, default 16, entry count, power of two, min 4.
REQ-003 SHALL have parameter TAG_W, default $clog2(DEPTH), tag width.
REQ-004 SHALL have parameter REG_ADDR_WIDTH, default 5, architectural register index width.
REQ-005 SHALL have parameter CDB_PORTS, default 2, number of result-broadcast ports.
REQ-006 SHALL have ports: clk in 1, sole clock, rising edge; rst in 1, reset, synchronous, active-high.
REQ-007 SHALL have ports: stall_i in 1, freeze issue/commit; flush_i in 1, discard all entries.
REQ-008 SHALL have ports: issue_en_i in 1, allocate request; issue_dest_i in REG_ADDR_WIDTH, destination register; issue_tag_o out TAG_W, tag of the allocated entry (tail).
REQ-009 SHALL have ports: rs1_tag_i, rs2_tag_i in TAG_W, operand lookup tags; rs1_valid_o, rs2_valid_o out 1; rs1_value_o, rs2_value_o out XLEN.
REQ-010 SHALL have ports: cdb_valid_i in CDB_PORTS; cdb_tag_i in CDB_PORTS*TAG_W; cdb_value_i in CDB_PORTS*XLEN; port p occupies slice p.
REQ-011 SHALL have ports: commit_ready_i in 1, regfile accepts; commit_en_o out 1; commit_dest_o out REG_ADDR_WIDTH; commit_value_o out XLEN.
REQ-012 SHALL have ports: full_o, empty_o out 1; count_o out TAG_W+1, occupied entries.

Function
REQ-013 SHALL hold per entry: busy, valid, dest, value; head, tail pointers TAG_W wide, wrapping modulo DEPTH; count register.
REQ-014 SHALL drive issue_tag_o = tail, full_o = (count==DEPTH), empty_o = (count==0), all from registered state.
REQ-015 SHALL allocate on issue_en_i & !full_o & !stall_i & !flush_i: entry[tail] busy=1, valid=0, dest=issue_dest_i; tail+1 next edge.
REQ-016 SHALL ignore issue when full_o is 1, even if a commit occurs the same cycle.
REQ-017 SHALL, per CDB port with valid set and entry busy, write value and set valid next edge; writes to non-busy entries are ignored.
REQ-018 SHALL resolve two ports hitting the same tag in one cycle in favour of the lowest port index.
REQ-019 SHALL accept CDB writes while stall_i is 1.
REQ-020 SHALL drive commit_en_o combinationally = busy[head] & valid[head] & commit_ready_i & !stall_i & !flush_i, with commit_dest_o/commit_value_o = entry[head] fields.
REQ-021 SHALL on commit_en_o clear busy[head], head+1 next edge; at most one commit per cycle.
REQ-022 SHALL update count by +1 issue only, -1 commit only, unchanged for both or neither.
REQ-023 SHALL drive rsN_valid_o/rsN_value_o from entry[rsN_tag_i] if valid; otherwise bypass from the lowest CDB port whose valid is set with matching tag to a busy entry; else valid 0, value 0.
REQ-024 SHALL on flush_i clear all busy/valid, head=tail=count=0 next edge; flush overrides stall, issue, CDB and commit.
REQ-025 SHALL have no internal latency beyond one edge: issued entry visible to lookup and commit the cycle after allocation.

Reset
REQ-026 SHALL on rst at a clock edge clear all busy/valid, head=tail=count=0, regardless of any other input, including mid-operation.
REQ-027 SHALL after reset present full_o=0, empty_o=1, count_o=0, issue_tag_o=0, commit_en_o=0, rsN_valid_o=0, rsN_value_o=0.

Verification (DEPTH=4, CDB_PORTS=2)
REQ-028 SHALL cover: reset, issue dest 8 -> tag 0; CDB0 tag 0 value 256; commit_ready_i=1 -> next cycle commit_en_o=1, dest 8, value 256, then empty_o=1.
REQ-029 SHALL cover: four issues, then issue_en_i with commit the same cycle -> fifth issue ignored, count_o goes 4->3, tail wraps to 0.
REQ-030 SHALL cover: CDB0 and CDB1 both tag 1, values 16 and 32 -> entry 1 holds 16; rs1_tag_i=1 same cycle -> rs1_valid_o=1, rs1_value_o=16 (bypass).
REQ-031 SHALL cover: head valid, stall_i=1 -> commit_en_o=0, count unchanged; CDB write to tag 2 still lands; release stall -> commit proceeds.
REQ-032 SHALL cover: three entries busy, flush_i with issue_en_i and commit_ready_i -> next cycle empty_o=1, count_o=0, issue_tag_o=0, no commit.
REQ-033 SHALL cover: rst asserted with 2 entries valid -> all outputs at REQ-027 values next cycle.
